// File: rtl/fifo_wrap.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : fifo_wrap                                                         |
// | Brief    : Single-clock synchronous FIFO, 2^ADDR_LEN x DATA_LEN, registered  |
// |            read data and registered full/empty flags.                        |
// | Revision : 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
module fifo_wrap #(
   parameter int DATA_LEN = 32,
   parameter int ADDR_LEN = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                write_en,
   input  logic                read_en,
   input  logic [DATA_LEN-1:0] wdata_i,
   output logic [DATA_LEN-1:0] rdata_o,
   output logic                rempty_o,
   output logic                wfull_o
);

   localparam int c_DEPTH = 1 << ADDR_LEN;

   logic [DATA_LEN-1:0] r_mem [c_DEPTH];

   logic [ADDR_LEN:0]   r_wptr;
   logic [ADDR_LEN:0]   r_rptr;
   logic [DATA_LEN-1:0] r_rdata;
   logic                r_empty;
   logic                r_full;

   logic                w_wr_acc;
   logic                w_rd_acc;
   logic [ADDR_LEN:0]   w_wptr_nxt;
   logic [ADDR_LEN:0]   w_rptr_nxt;
   logic                w_empty_nxt;
   logic                w_full_nxt;

   // Acceptance uses the flags as they stood before the edge, so a write while
   // full or a read while empty is simply dropped.
   assign w_wr_acc   = write_en & ~r_full;
   assign w_rd_acc   = read_en  & ~r_empty;

   assign w_wptr_nxt = r_wptr + {{ADDR_LEN{1'b0}}, w_wr_acc};
   assign w_rptr_nxt = r_rptr + {{ADDR_LEN{1'b0}}, w_rd_acc};

   assign w_empty_nxt = (w_wptr_nxt == w_rptr_nxt);
   assign w_full_nxt  = (w_wptr_nxt[ADDR_LEN] != w_rptr_nxt[ADDR_LEN]) &&
                        (w_wptr_nxt[ADDR_LEN-1:0] == w_rptr_nxt[ADDR_LEN-1:0]);

   // Storage is deliberately left out of reset; the pointers alone define contents.
   always_ff @(posedge clk) begin
      if (w_wr_acc) begin
         r_mem[r_wptr[ADDR_LEN-1:0]] <= wdata_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_rdata <= '0;
         r_empty <= 1'b1;
         r_full  <= 1'b0;
      end else begin
         r_wptr  <= w_wptr_nxt;
         r_rptr  <= w_rptr_nxt;
         r_empty <= w_empty_nxt;
         r_full  <= w_full_nxt;
         if (w_rd_acc) begin
            r_rdata <= r_mem[r_rptr[ADDR_LEN-1:0]];
         end
      end
   end

   assign rdata_o  = r_rdata;
   assign rempty_o = r_empty;
   assign wfull_o  = r_full;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wrap.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_fifo_wrap                                                      |
// | Brief    : Scoreboard bench for fifo_wrap against a queue reference model.   |
// | Revision : 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
module tb_fifo_wrap;

   localparam int DATA_LEN = 32;
   localparam int ADDR_LEN = 4;
   localparam int DEPTH    = 1 << ADDR_LEN;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                write_en = 1'b0;
   logic                read_en = 1'b0;
   logic [DATA_LEN-1:0] wdata_i = '0;
   logic [DATA_LEN-1:0] rdata_o;
   logic                rempty_o;
   logic                wfull_o;

   fifo_wrap #(.DATA_LEN(DATA_LEN), .ADDR_LEN(ADDR_LEN)) dut (
      .clk      (clk),
      .rst      (rst),
      .write_en (write_en),
      .read_en  (read_en),
      .wdata_i  (wdata_i),
      .rdata_o  (rdata_o),
      .rempty_o (rempty_o),
      .wfull_o  (wfull_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int rst_count = 0;
   int rd_idx = 0;

   logic [DATA_LEN-1:0] model_q[$];   // words the FIFO should currently hold
   logic [DATA_LEN-1:0] exp_q[$];     // log of every word that should be read out

   task automatic chk(input string nm, input logic [DATA_LEN-1:0] act,
                      input logic [DATA_LEN-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic chk_flags();
      chk("rempty_o", {31'd0, rempty_o}, {31'd0, model_q.size() == 0});
      chk("wfull_o",  {31'd0, wfull_o},  {31'd0, model_q.size() == DEPTH});
   endtask

   // One clock cycle, entered and left at a falling edge.
   task automatic step(input logic we, input logic re, input logic [DATA_LEN-1:0] d);
      bit wa;
      bit ra;
      chk_flags();
      write_en = we;
      read_en  = re;
      wdata_i  = d;
      wa = we && (model_q.size() < DEPTH);
      ra = re && (model_q.size() > 0);
      if (ra) exp_q.push_back(model_q.pop_front());
      if (wa) model_q.push_back(d);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic reset_pulse();
      step(1'b0, 1'b0, '0);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_rempty", {31'd0, rempty_o}, 32'd1);
      chk("rst_wfull",  {31'd0, wfull_o},  32'd0);
      chk("rst_rdata",  rdata_o, '0);
      #1 rst = 1'b0;
      model_q.delete();
      rst_count++;
      @(negedge clk);
   endtask

   // Monitor: whenever the DUT accepts a read, the next word on rdata_o must be
   // the next one in the expected log; otherwise rdata_o must hold.
   initial begin
      int seen_rst = 0;
      logic hit;
      logic [DATA_LEN-1:0] last_rd = '0;
      forever begin
         @(posedge clk);
         hit = read_en && !rempty_o && !rst;
         @(negedge clk);
         if (rst || seen_rst != rst_count) begin
            seen_rst = rst_count;
            last_rd  = '0;
         end else if (hit) begin
            if (rd_idx < exp_q.size()) begin
               chk("rdata", rdata_o, exp_q[rd_idx]);
               last_rd = exp_q[rd_idx];
            end else begin
               checks++;
               errors++;
               $display("FAIL rd_unexpected actual=%h required=no_read at %0t", rdata_o, $time);
            end
            rd_idx++;
         end else begin
            chk("rdata_hold", rdata_o, last_rd);
         end
      end
   end

   initial begin
      // Reset held with a write pending: nothing may be stored.
      rst      = 1'b1;
      write_en = 1'b1;
      wdata_i  = 32'hFFFF_FFFF;
      repeat (10) @(negedge clk);
      chk("reset_rempty", {31'd0, rempty_o}, 32'd1);
      chk("reset_wfull",  {31'd0, wfull_o},  32'd0);
      chk("reset_rdata",  rdata_o, '0);
      rst      = 1'b0;
      write_en = 1'b0;
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b1, '0);

      // Fill, overflow attempt, drain.
      for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, DATA_LEN'(i));
      step(1'b1, 1'b0, 32'h0000_DEAD);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0);
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b1, '0);

      // Simultaneous write+read while full, then while empty.
      for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, $urandom);
      step(1'b1, 1'b1, 32'hBEEF_0001);
      step(1'b0, 1'b0, '0);
      for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 1'b1, '0);
      step(1'b1, 1'b1, 32'hBEEF_0002);
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b1, '0);
      step(1'b0, 1'b0, '0);

      // Streaming: consumer reads whenever non-empty, producer writes at random.
      for (int i = 0; i < 1000; i++)
         step(($urandom_range(0, 99) < 60) && !wfull_o, !rempty_o, $urandom);

      // Unconstrained random traffic, biased to reach both full and empty.
      for (int i = 0; i < 600; i++) begin
         int wp;
         wp = (i < 300) ? 80 : 25;
         step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < 100 - wp, $urandom);
      end
      for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b1, '0);

      // Mid-operation reset with five words stored.
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, $urandom);
      reset_pulse();
      step(1'b1, 1'b0, 32'hA5A5_A5A5);
      step(1'b0, 1'b1, '0);
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b0, '0);
      chk_flags();

      chk("reads_consumed", rd_idx, exp_q.size());
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fifo_wrap.md
Name:
fifo_wrap

Overview:
- Single-clock synchronous FIFO wrapper: 2^ADDR_LEN entries of DATA_LEN bits, with write/read enables and registered full/empty flags.
- Sits between a producer and a consumer in the same clock domain and buffers streaming data words.
- The consumer may read whenever rempty_o is low.
- The producer may write whenever wfull_o is low.

Parameters:
- DATA_LEN, 32, width of each stored word and of wdata_i/rdata_o.
- ADDR_LEN, 4, address width; depth = 2^ADDR_LEN (16 by default).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- write_en  input  1  write request; accepted only when wfull_o=0.
- read_en  input  1  read request; accepted only when rempty_o=0.
- wdata_i  input  DATA_LEN  data written on an accepted write.
- rdata_o  output  DATA_LEN  registered read data.
- rempty_o  output  1  FIFO empty flag.
- wfull_o  output  1  FIFO full flag.

Behaviour:
- Storage: memory array of 2^ADDR_LEN x DATA_LEN; memory contents are not reset.
- Pointers: wptr and rptr are each ADDR_LEN+1 bits (address bits plus a wrap bit). Both reset to 0.
- Flags (derived from pointers, so they change only after a clock edge or on reset):
  - rempty_o = 1 when wptr == rptr.
  - wfull_o = 1 when the pointer MSBs differ and the lower ADDR_LEN bits are equal.
- Accepted write (write_en=1 and wfull_o=0 at the clock edge): mem[wptr[ADDR_LEN-1:0]] <= wdata_i; wptr <= wptr+1.
- Rejected write (write_en=1 while full): no state change; the data is dropped silently.
- Accepted read (read_en=1 and rempty_o=0 at the clock edge): rdata_o <= mem[rptr[ADDR_LEN-1:0]]; rptr <= rptr+1. The word is valid on rdata_o one cycle after the accepting edge.
- Rejected read (read_en=1 while empty): rdata_o holds its last value; no pointer change.
- rdata_o holds its value between reads.
- Simultaneous write and read:
  - Both accepted when neither flag blocks: occupancy unchanged, flags unchanged.
  - When full: the read is accepted and the write is rejected (the flag is sampled before the edge). Next cycle wfull_o=0.
  - When empty: the write is accepted and the read is rejected. Next cycle rempty_o=0, with the first word available to read.
- Wrap-around: pointers increment modulo 2^(ADDR_LEN+1); the address uses the low ADDR_LEN bits. Data order is preserved across unlimited wraps.
- Reset values: wptr=rptr=0, rdata_o=0, rempty_o=1, wfull_o=0.
  - Asserting rst mid-operation immediately (asynchronously) empties the FIFO and clears rdata_o.
  - Stored words are discarded logically.
  - Operation resumes on the first rising edge after rst deasserts.
- Occupancy invariant: 0..2^ADDR_LEN. Both flags are never high at the same time.
- No overflow or underflow is possible: writes while full and reads while empty are ignored.

Test Plan:
- Reset: hold rst=1 for 100 ns with write_en=1 and wdata_i=32'hFFFFFFFF -> rempty_o=1, wfull_o=0, rdata_o=0; no word stored after release.
- Fill: write 16 words 0x1..0x10 with read_en=0 -> rempty_o drops after the first edge; wfull_o=1 after the 16th edge.
- Overflow: a 17th write of 0xDEAD while full -> ignored. Then read 16 words -> rdata_o = 0x1..0x10 in order (each valid one cycle after its accepting edge); rempty_o=1 after the last; the 0xDEAD word never appears.
- Concurrent streaming: read_en = !rempty_o with random writes gated by !wfull_o for 1000 cycles -> the read sequence matches a reference queue exactly; no flag violations across multiple pointer wraps.
- Simultaneous events:
  - Write+read while full -> the read returns the oldest word and wfull_o=0 next cycle.
  - Write+read while empty -> rdata_o unchanged and rempty_o=0 next cycle.
- Mid-operation reset: with 5 words stored, pulse rst between edges -> rempty_o=1 and rdata_o=0 immediately. A subsequent write of 0xA5A5A5A5 then read returns 0xA5A5A5A5.
